// File: rtl/led_pkg.sv
// led_pkg: shared mode encoding and PWM constants for the LED controller.
package led_pkg;
   localparam int LED_MODE_W = 2;
   localparam int PWM_STEPS = 15;
   typedef enum logic [LED_MODE_W-1:0] {
      LED_MODE_OFF   = 2'd0,
      LED_MODE_ON    = 2'd1,
      LED_MODE_BLINK = 2'd2,
      LED_MODE_BURST = 2'd3
   } led_mode_e;
   function automatic logic is_running(led_mode_e m);
      return m == LED_MODE_BLINK || m == LED_MODE_BURST;
   endfunction
endpackage

// File: rtl/led_blink_ctrl_if.sv
// led_blink_ctrl_if: config bus and LED outputs of led_blink_ctrl.
// cfg_bright exists only when LED_BRIGHT_EN is defined.
interface led_blink_ctrl_if
   import led_pkg::*;
#(
   parameter int CH_NUM   = 4,
   parameter int PERIOD_W = 10,
   parameter int CNT_W    = 4
) ();
   localparam int CH_W = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
   logic                  cfg_we;
   logic [CH_W-1:0]       cfg_ch;
   logic [LED_MODE_W-1:0] cfg_mode;
   logic [PERIOD_W-1:0]   cfg_half_period;
   logic [CNT_W-1:0]      cfg_count;
`ifdef LED_BRIGHT_EN
   logic [3:0]            cfg_bright;
`endif
   logic                  tick;
   logic [CH_NUM-1:0]     led;
   logic [CH_NUM-1:0]     burst_done;
   modport master (
      output cfg_we, cfg_ch, cfg_mode, cfg_half_period, cfg_count,
`ifdef LED_BRIGHT_EN
      output cfg_bright,
`endif
      input  tick, led, burst_done
   );
   modport slave (
      input  cfg_we, cfg_ch, cfg_mode, cfg_half_period, cfg_count,
`ifdef LED_BRIGHT_EN
      input  cfg_bright,
`endif
      output tick, led, burst_done
   );
endinterface

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running prescaler, registered 1-clk tick every TICK_DIV clocks.
module led_tick_gen #(
   parameter int TICK_DIV = 50_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int CW = $clog2(TICK_DIV);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q;
   assign cnt_d = (cnt_q == CW'(TICK_DIV - 1)) ? '0 : cnt_q + CW'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= cnt_d == CW'(TICK_DIV - 1);
      end
   assign tick = tick_q;
endmodule

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: CH_NUM LED channels (OFF/ON/BLINK/BURST) paced by a shared tick.
// Optional LED_BRIGHT_EN adds per-channel 15-step PWM brightness on led.
module led_blink_ctrl
   import led_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int TICK_HZ     = 1_000,
   parameter int CH_NUM      = 4,
   parameter int PERIOD_W    = 10,
   parameter int CNT_W       = 4
) (
   input logic             clk,
   input logic             rst_n,
   led_blink_ctrl_if.slave bus
);
   localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int CH_W = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
   logic              tick;
   logic [CH_NUM-1:0] led_v, done_v;
   led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );
   assign bus.tick       = tick;
   assign bus.led        = led_v;
   assign bus.burst_done = done_v;
`ifdef LED_BRIGHT_EN
   logic [3:0] pwm_q, pwm_d;
   assign pwm_d = (pwm_q == 4'(PWM_STEPS - 1)) ? 4'd0 : pwm_q + 4'd1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pwm_q <= 4'd0;
      else pwm_q <= pwm_d;
`endif
   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      led_mode_e           mode_q, mode_d;
      logic [PERIOD_W-1:0] hp_q, hp_d, ph_q, ph_d;
      logic [CNT_W-1:0]    rem_q, rem_d;
      logic                st_q, st_d, done_q, done_d;
      logic                wr, wrap;
      // Out-of-range cfg_ch never matches any channel index, so it is dropped.
      assign wr   = bus.cfg_we && bus.cfg_ch == CH_W'(c);
      assign wrap = ph_q == hp_q - PERIOD_W'(1);
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            mode_q <= LED_MODE_OFF;
            hp_q   <= '0;
            ph_q   <= '0;
            rem_q  <= '0;
            st_q   <= 1'b0;
            done_q <= 1'b0;
         end else begin
            mode_q <= mode_d;
            hp_q   <= hp_d;
            ph_q   <= ph_d;
            rem_q  <= rem_d;
            st_q   <= st_d;
            done_q <= done_d;
         end
      always_comb begin
         mode_d = mode_q;
         hp_d   = hp_q;
         ph_d   = ph_q;
         rem_d  = rem_q;
         st_d   = st_q;
         done_d = 1'b0;
         if (wr) begin
            mode_d = led_mode_e'(bus.cfg_mode);
            hp_d   = (bus.cfg_half_period == '0) ? PERIOD_W'(1) : bus.cfg_half_period;
            ph_d   = '0;
            rem_d  = bus.cfg_count;
            st_d   = bus.cfg_mode != LED_MODE_OFF;
         end else if (mode_q == LED_MODE_BURST && rem_q == '0) begin
            mode_d = LED_MODE_OFF;
            st_d   = 1'b0;
            done_d = 1'b1;
         end else if (is_running(mode_q) && tick) begin
            ph_d = wrap ? '0 : ph_q + PERIOD_W'(1);
            if (wrap) begin
               st_d = !st_q;
               // Each falling edge closes one burst pulse; the last one ends the burst.
               if (mode_q == LED_MODE_BURST && st_q) begin
                  rem_d = rem_q - CNT_W'(1);
                  if (rem_q == CNT_W'(1)) begin
                     mode_d = LED_MODE_OFF;
                     done_d = 1'b1;
                  end
               end
            end
         end
      end
      assign done_v[c] = done_q;
`ifdef LED_BRIGHT_EN
      logic [3:0] br_q, br_d;
      logic       led_q, led_d;
      assign br_d = wr ? bus.cfg_bright : br_q;
      always_comb led_d = st_d && (pwm_d < br_d);
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            br_q  <= 4'd15;
            led_q <= 1'b0;
         end else begin
            br_q  <= br_d;
            led_q <= led_d;
         end
      assign led_v[c] = led_q;
`else
      assign led_v[c] = st_q;
`endif
   end
endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb_led_blink_ctrl: directed and random checks of led_blink_ctrl against a tick-count model.
// Works with or without LED_BRIGHT_EN.
module tb_led_blink_ctrl;
   localparam int CH = 4, PW = 10, CW = 4, DIV = 10;
   logic clk = 1'b0, rst_n = 1'b0;
   int   errors = 0, checks = 0;
   bit   chk_en = 1'b0;
   int   m_e, m_mode[CH], m_hp[CH], m_cnt[CH], m_n[CH], m_br[CH];
   bit   m_st[CH], m_done[CH];

   always #5 clk = ~clk;

   led_blink_ctrl_if #(.CH_NUM(CH), .PERIOD_W(PW), .CNT_W(CW)) bus ();
   led_blink_ctrl_if #(.CH_NUM(3), .PERIOD_W(PW), .CNT_W(CW)) bus3 ();

   led_blink_ctrl #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .CH_NUM(CH), .PERIOD_W(PW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   led_blink_ctrl #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .CH_NUM(3), .PERIOD_W(PW), .CNT_W(CW)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3));

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each channel counts ticks since its last write; the LED level and the
   // end of a burst follow from that count divided by the half-period.
   task automatic model_reset();
      m_e = 0;
      for (int c = 0; c < CH; c++) begin
         m_mode[c] = 0; m_hp[c] = 1; m_cnt[c] = 0; m_n[c] = 0;
         m_br[c] = 15; m_st[c] = 0; m_done[c] = 0;
      end
   endtask

   task automatic model_step();
      bit tk = (m_e % DIV) == DIV - 1;
      m_e++;
      for (int c = 0; c < CH; c++) begin
         int k;
         m_done[c] = 0;
         if (bus.cfg_we && bus.cfg_ch == c) begin
            m_mode[c] = int'(bus.cfg_mode);
            m_hp[c]   = bus.cfg_half_period == 0 ? 1 : int'(bus.cfg_half_period);
            m_cnt[c]  = int'(bus.cfg_count);
            m_n[c]    = 0;
            m_st[c]   = m_mode[c] != 0;
`ifdef LED_BRIGHT_EN
            m_br[c]   = int'(bus.cfg_bright);
`endif
         end else if (m_mode[c] == 3 && m_cnt[c] == 0) begin
            m_mode[c] = 0; m_st[c] = 0; m_done[c] = 1;
         end else if (tk && m_mode[c] >= 2) begin
            m_n[c]++;
            k = m_n[c] / m_hp[c];
            if (m_mode[c] == 3 && k >= 2 * m_cnt[c] - 1) begin
               m_mode[c] = 0; m_st[c] = 0; m_done[c] = 1;
            end else m_st[c] = (k % 2) == 0;
         end
      end
   endtask

   function automatic int exp_led();
      int v = 0;
      for (int c = 0; c < CH; c++) begin
         bit lit = m_st[c];
`ifdef LED_BRIGHT_EN
         lit = lit && ((m_e % 15) < m_br[c]);
`endif
         if (lit) v |= 1 << c;
      end
      return v;
   endfunction

   function automatic int exp_done();
      int v = 0;
      for (int c = 0; c < CH; c++) if (m_done[c]) v |= 1 << c;
      return v;
   endfunction

   always @(negedge clk)
      if (chk_en) begin
         check("tick", int'(bus.tick), int'((m_e % DIV) == DIV - 1));
         check("led", int'(bus.led), exp_led());
         check("burst_done", int'(bus.burst_done), exp_done());
      end

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic wr(int ch, int mode, int hp, int cnt, int br);
      bus.cfg_we = 1'b1;
      bus.cfg_ch = 2'(ch);
      bus.cfg_mode = 2'(mode);
      bus.cfg_half_period = PW'(hp);
      bus.cfg_count = CW'(cnt);
`ifdef LED_BRIGHT_EN
      bus.cfg_bright = 4'(br);
`endif
      cyc();
      bus.cfg_we = 1'b0;
   endtask

   initial begin
      int t[3];
      int k, prev, rises, dones, coincide, lit;
      bit found;
      bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_mode = 0; bus.cfg_half_period = 0; bus.cfg_count = 0;
      bus3.cfg_we = 0; bus3.cfg_ch = 0; bus3.cfg_mode = 0; bus3.cfg_half_period = 0; bus3.cfg_count = 0;
`ifdef LED_BRIGHT_EN
      bus.cfg_bright = 4'd15;
      bus3.cfg_bright = 4'd15;
`endif
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_led", int'(bus.led), 0);
      check("reset_done", int'(bus.burst_done), 0);
      check("reset_tick", int'(bus.tick), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Prescaler: first tick after 9 edges (10th cycle), then every 10 clk.
      k = 0;
      for (int i = 1; i <= 30 && k < 2; i++) begin
         cyc();
         if (bus.tick) t[k++] = i;
      end
      check("first_tick_edge", t[0], 9);
      check("tick_period", t[1] - t[0], 10);

      // BLINK ch0, half_period 3.
      wr(0, 2, 3, 0, 15);
      check("blink_lit_after_write", int'(bus.led[0]), 1);
      check("blink_others_dark", int'(bus.led[3:1]), 0);
      k = 0; prev = 1; t = '{0, 0, 0};
      for (int i = 1; i <= 150 && k < 3; i++) begin
         cyc();
         if (int'(bus.led[0]) != prev) begin t[k++] = i; prev = int'(bus.led[0]); end
      end
      check("blink_toggles", k, 3);
      check("blink_first_interval", int'(t[0] >= 20 && t[0] <= 30), 1);
      check("blink_interval_1", t[1] - t[0], 30);
      check("blink_interval_2", t[2] - t[1], 30);

      // BURST ch1, half_period 2, count 3.
      prev = int'(bus.led[1]); rises = 0; dones = 0; coincide = 0;
      wr(1, 3, 2, 3, 15);
      for (int i = 0; i < 200; i++) begin
         if (i > 0) cyc();
         if (bus.led[1] && prev == 0) rises++;
         if (bus.burst_done[1]) begin
            dones++;
            if (!bus.led[1] && prev == 1) coincide++;
         end
         prev = int'(bus.led[1]);
      end
      check("burst_pulses", rises, 3);
      check("burst_done_count", dones, 1);
      check("burst_done_at_fall", coincide, 1);
      check("burst_led_after", int'(bus.led[1]), 0);

      // Write ch2 in a tick cycle with half_period 0: write wins, toggles every tick.
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (bus.tick) found = 1;
         else cyc();
      end
      check("tick_found", int'(found), 1);
      wr(2, 2, 0, 0, 15);
      check("hp0_lit_after_write", int'(bus.led[2]), 1);
      repeat (9) cyc();
      check("hp0_held_until_tick", int'(bus.led[2]), 1);
      cyc();
      check("hp0_toggle_tick1", int'(bus.led[2]), 0);
      repeat (10) cyc();
      check("hp0_toggle_tick2", int'(bus.led[2]), 1);

`ifdef LED_BRIGHT_EN
      wr(3, 1, 1, 0, 5);
      lit = 0;
      for (int i = 0; i < 30; i++) begin cyc(); lit += int'(bus.led[3]); end
      check("bright5_duty", lit, 10);
      wr(3, 1, 1, 0, 0);
      lit = 0;
      for (int i = 0; i < 30; i++) begin cyc(); lit += int'(bus.led[3]); end
      check("bright0_dark", lit, 0);
`endif

      // Random config traffic checked cycle by cycle against the model.
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 5) == 0)
            wr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 4), $urandom_range(0, 15));
         else begin
            bus.cfg_ch = 2'($urandom_range(0, 3));
            bus.cfg_mode = 2'($urandom_range(0, 3));
            bus.cfg_half_period = PW'($urandom_range(0, 1023));
            bus.cfg_count = CW'($urandom_range(0, 15));
            cyc();
         end
      end

      // Asynchronous reset in the middle of a burst.
      wr(1, 3, 2, 3, 15);
      repeat (5) cyc();
      check("burst_lit_before_reset", int'(bus.led[1]), 1);
      #2 rst_n = 1'b0;
      chk_en = 1'b0;
      #1;
      check("async_reset_led", int'(bus.led), 0);
      check("async_reset_done", int'(bus.burst_done), 0);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      dones = 0; lit = 0;
      for (int i = 0; i < 80; i++) begin
         cyc();
         dones += $countones(bus.burst_done);
         lit += $countones(bus.led);
      end
      check("no_done_after_reset", dones, 0);
      check("dark_after_reset", lit, 0);

      // Out-of-range channel on a 3-channel instance.
      bus3.cfg_we = 1'b1; bus3.cfg_ch = 2'd3; bus3.cfg_mode = 2'd1; bus3.cfg_half_period = PW'(1);
      cyc();
      bus3.cfg_we = 1'b0;
      repeat (2) cyc();
      check("invalid_ch_ignored", int'(bus3.led), 0);
      bus3.cfg_we = 1'b1; bus3.cfg_ch = 2'd2;
      cyc();
      bus3.cfg_we = 1'b0;
      cyc();
      check("valid_ch2_on", int'(bus3.led), 4);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
